sdram_port_arb: RTL

Round-robin request scheduler in front of the SDRAM controller's single write/read trigger pair. Three client ports (for example camera writer, display reader and host) each post one burst request with a direction and a target address. The block serialises the requests into one `wr_trig`/`rd_trig` pulse at a time, presents the target address, and waits for the controller's end-of-burst flag. It then acknowledges the requesting port and moves on. It sits between client logic and `sdram_top`, and gates all traffic on `flag_init_end`.

---
 rtl/sdram_port_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//   Round-robin scheduler that serialises burst requests from three client ports
//   onto the SDRAM controller's single write/read trigger pair. One burst is in
//   flight at a time; the block waits for the controller's end-of-burst flag (or
//   a timeout) before acknowledging the port and arbitrating again.
//
// Ports
//   sclk          clock, rising edge
//   reset         asynchronous, active-low reset
//   flag_init_end SDRAM initialisation complete; only checked before first use
//   port_req      per-port request level, held until the matching port_done
//   port_we       per-port direction (1 = write, 0 = read)
//   port_addr     per-port address, port i at [i*ADDR_W +: ADDR_W]
//   cmd_done      end-of-burst pulse from the controller
//   wr_trig       one-cycle write trigger
//   rd_trig       one-cycle read trigger
//   cmd_addr      address of the granted burst
//   port_gnt      one-hot grant, ISSUE through WAIT
//   port_done     one-hot one-cycle completion pulse
//   busy          a burst is being issued, waited on or retired
//   timeout_err   sticky, set when a burst is abandoned
module sdram_port_arb #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  flag_init_end,
    input  logic [2:0]            port_req,
    input  logic [2:0]            port_we,
    input  logic [3*ADDR_W-1:0]   port_addr,
    input  logic                  cmd_done,
    output logic                  wr_trig,
    output logic                  rd_trig,
    output logic [ADDR_W-1:0]     cmd_addr,
    output logic [2:0]            port_gnt,
    output logic [2:0]            port_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StInit, StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q;
    logic [1:0]      last_grant_q;
    logic [1:0]      sel_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_nxt;

    logic [1:0]        cand0, cand1, cand2, pick;
    logic [ADDR_W-1:0] pick_addr;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search order starts one past the last served port, so a port that was
    // just served is considered last.
    always_comb begin
        cand0 = next_port(last_grant_q);
        cand1 = next_port(cand0);
        cand2 = next_port(cand1);
        pick  = cand2;
        if (port_req[cand1]) pick = cand1;
        if (port_req[cand0]) pick = cand0;
        pick_addr = port_addr[0 +: ADDR_W];
        case (pick)
            2'd1:    pick_addr = port_addr[ADDR_W +: ADDR_W];
            2'd2:    pick_addr = port_addr[2*ADDR_W +: ADDR_W];
            default: pick_addr = port_addr[0 +: ADDR_W];
        endcase
    end

    // The abandon decision looks at the post-increment count so DONE lands
    // exactly TIMEOUT cycles after the trigger cycle.
    assign cnt_nxt = cnt_q + 1'b1;

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q      <= StInit;
            last_grant_q <= 2'd2;
            sel_q        <= 2'd0;
            cnt_q        <= '0;
            wr_trig      <= 1'b0;
            rd_trig      <= 1'b0;
            cmd_addr     <= '0;
            port_gnt     <= 3'b000;
            port_done    <= 3'b000;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wr_trig   <= 1'b0;
            rd_trig   <= 1'b0;
            port_done <= 3'b000;
            unique case (state_q)
                StInit: begin
                    if (flag_init_end) state_q <= StIdle;
                end
                StIdle: begin
                    if (|port_req) begin
                        sel_q    <= pick;
                        cmd_addr <= pick_addr;
                        wr_trig  <= port_we[pick];
                        rd_trig  <= ~port_we[pick];
                        port_gnt <= 3'b001 << pick;
                        busy     <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_nxt;
                    if (cmd_done) begin
                        port_gnt  <= 3'b000;
                        port_done <= 3'b001 << sel_q;
                        state_q   <= StDone;
                    end else if (cnt_nxt == CntLast) begin
                        timeout_err <= 1'b1;
                        port_gnt    <= 3'b000;
                        port_done   <= 3'b001 << sel_q;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    last_grant_q <= sel_q;
                    busy         <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule
